// File: rtl/button_debouncer_pkg.sv
// Shared types and constants for the button debouncer.
// FSM encoding and board clock rate.
package button_debouncer_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } db_state_t;

  localparam int CLK_HZ = 50_000_000;

  function automatic logic is_wait(input db_state_t s);
    return (s == WAIT_HI) || (s == WAIT_LO);
  endfunction

endpackage

// File: rtl/signal_synchronizer.sv
// Multi-flop synchronizer for asynchronous inputs.
// Reset value is loaded into every stage.
module signal_synchronizer #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ff <= {STAGES{RESET_VAL}};
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Debouncer: synchronizer followed by a counter-qualified
// four-state filter producing a clean registered level.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int INVERT          = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic debounced,
  output logic busy
);

  localparam int CNT_WIDTH = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] LAST =
    CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic INV = 1'(INVERT);

  logic sync_q;
  logic sync_sig;

  signal_synchronizer #(
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(INV)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (raw_in),
    .q    (sync_q)
  );

  assign sync_sig = sync_q ^ INV;

  db_state_t            state, state_n;
  logic [CNT_WIDTH-1:0] count, count_n;
  logic                 deb_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= STABLE_LO;
      count     <= '0;
      debounced <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      count     <= count_n;
      debounced <= deb_n;
      busy      <= is_wait(state_n);
    end
  end

  // Any reversal while waiting falls back to the old stable level.
  always_comb begin
    state_n = state;
    count_n = count;
    deb_n   = debounced;
    case (state)
      STABLE_LO: begin
        if (sync_sig) begin
          state_n = WAIT_HI;
          count_n = '0;
        end
      end
      WAIT_HI: begin
        if (!sync_sig) begin
          state_n = STABLE_LO;
          count_n = '0;
        end else if (count == LAST) begin
          state_n = STABLE_HI;
          deb_n   = 1'b1;
          count_n = '0;
        end else begin
          count_n = count + 1'b1;
        end
      end
      STABLE_HI: begin
        if (!sync_sig) begin
          state_n = WAIT_LO;
          count_n = '0;
        end
      end
      WAIT_LO: begin
        if (sync_sig) begin
          state_n = STABLE_HI;
          count_n = '0;
        end else if (count == LAST) begin
          state_n = STABLE_LO;
          deb_n   = 1'b0;
          count_n = '0;
        end else begin
          count_n = count + 1'b1;
        end
      end
      default: begin
        state_n = STABLE_LO;
        count_n = '0;
        deb_n   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer against a
// run-length reference model of the filter.
module tb_button_debouncer;

  localparam int D = 4;
  localparam int S = 2;

  logic clk = 1'b0;
  logic reset;
  logic raw_in;
  logic debounced;
  logic busy;

  always #5 clk = ~clk;

  button_debouncer #(
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(D),
    .INVERT         (1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .raw_in   (raw_in),
    .debounced(debounced),
    .busy     (busy)
  );

  typedef struct {
    logic deb;
    logic bsy;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  logic dly[$];
  logic m_deb;
  int   run;

  task automatic chk(input string nm, input logic act,
                     input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string nm, input int act,
                         input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    dly.delete();
    repeat (S) dly.push_back(1'b1);
    m_deb = 1'b0;
    run   = 0;
  endtask

  // Model: the filter sees the pin S edges late, inverted;
  // the level flips once D+1 consecutive samples disagree.
  task automatic step(input logic v);
    logic samp;
    raw_in = v;
    samp = dly.pop_front() ^ 1'b1;
    dly.push_back(v);
    if (samp != m_deb) run++;
    else run = 0;
    if (run == D + 1) begin
      m_deb = ~m_deb;
      run   = 0;
    end
    sb.push_back('{m_deb, samp != m_deb});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_lat(input logic v, input int n,
                         output int lat_d, output int lat_b);
    logic d0;
    d0 = debounced;
    lat_d = -1;
    lat_b = -1;
    for (int i = 1; i <= n; i++) begin
      step(v);
      if (lat_b < 0 && busy) lat_b = i;
      if (lat_d < 0 && debounced !== d0) lat_d = i;
    end
  endtask

  exp_t e;
  logic prev_deb = 1'b0;
  int   since = 1000;

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_debounced", debounced, e.deb);
      chk("sb_busy", busy, e.bsy);
    end
    if (!reset) begin
      since = 1000;
    end else if (debounced !== prev_deb) begin
      checks++;
      if (since < D + 1) begin
        errors++;
        $display("FAIL toggle_gap: got %0d expected >= %0d",
                 since, D + 1);
      end
      since = 1;
    end else begin
      since++;
    end
    prev_deb = debounced;
  end

  int ld, lb, hold;
  logic v;

  initial begin
    reset  = 1'b0;
    raw_in = 1'b0;
    model_reset();
    repeat (4) begin
      @(negedge clk);
      raw_in = 1'($urandom);
      #1;
      chk("rst_debounced", debounced, 1'b0);
      chk("rst_busy", busy, 1'b0);
    end
    @(negedge clk);
    raw_in = 1'b1;
    reset  = 1'b1;
    repeat (20) step(1'b1);
    chk("idle_debounced", debounced, 1'b0);

    run_lat(1'b0, 12, ld, lb);
    chk_int("press_busy_lat", lb, 3);
    chk_int("press_deb_lat", ld, 7);
    chk("press_level", debounced, 1'b1);
    run_lat(1'b1, 12, ld, lb);
    chk_int("release_deb_lat", ld, 7);

    repeat (3) step(1'b0);
    repeat (10) step(1'b1);
    chk("glitch_debounced", debounced, 1'b0);
    chk("glitch_busy", busy, 1'b0);

    for (int i = 0; i < 9; i++) step(1'((i + 1) % 2));
    run_lat(1'b0, 12, ld, lb);
    chk_int("bounce_press_lat", ld, 7);
    run_lat(1'b1, 12, ld, lb);
    chk_int("bounce_release_lat", ld, 7);
    chk_int("bounce_release_busy", lb, 3);

    repeat (5) step(1'b0);
    chk("midwait_busy", busy, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_busy", busy, 1'b0);
    chk("async_debounced", debounced, 1'b0);
    @(negedge clk);
    @(negedge clk);
    raw_in = 1'b1;
    reset  = 1'b1;
    model_reset();
    run_lat(1'b0, 12, ld, lb);
    chk_int("restart_deb_lat", ld, 7);
    chk_int("restart_busy_lat", lb, 3);

    for (int c = 0; c < 20000; c += hold) begin
      v    = 1'($urandom);
      hold = $urandom_range(1, 10);
      repeat (hold) step(v);
    end
    repeat (12) step(1'b1);
    chk("soak_final", debounced, 1'b0);
    @(posedge clk);
    #2;
    chk_int("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
